fp_square_seq: RTL
==================

Name: fp_square_seq

Overview:
- Iterative unsigned fixed-point squarer; the inverse operation of the team's sequential square-root primitive.
- Computes out = (in*in) >> FRAC_WIDTH using a radix-2 shift-add recurrence, one multiplier bit per cycle.
- Uses the same go/done latency-insensitive interface as the other multi-cycle math primitives, so the compiler can schedule it interchangeably.
- Used for variance/norm computations and for round-trip checking of the sqrt primitive.

Parameters:
- WIDTH, 32, total operand and result width in bits.
- INT_WIDTH, 16, integer bits of operand and result; INT_WIDTH + FRAC_WIDTH must equal WIDTH.
- FRAC_WIDTH, 16, fractional bits of operand and result; 0 gives plain integer squaring.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- go  input  1  start request; sampled only in IDLE.
- in  input  WIDTH  unsigned fixed-point operand; captured on the start edge.
- out  output  WIDTH  registered result; holds its value until the next completion.
- done  output  1  one-cycle pulse marking out valid.
- overflow  output  1  registered with out; high if the result was truncated.

Behaviour:
- Reset (async, any state): state=IDLE, out=0, done=0, overflow=0; internal accumulator, counter and operand registers cleared. A reset mid-operation aborts the computation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: if go=1 at a rising edge, capture in into both the multiplicand and multiplier registers, clear the 2*WIDTH-bit accumulator, set idx=0, go to RUN. Otherwise stay.
- RUN, each edge:
  - if the multiplier LSB is 1, acc += multiplicand << idx (full 2*WIDTH-bit add, no loss);
  - shift the multiplier right by 1;
  - idx += 1.
  - After the edge where idx reaches WIDTH-1, i.e. the WIDTH-th iteration, go to DONE.
- On that same final edge:
  - out <= bits [FRAC_WIDTH+WIDTH-1 : FRAC_WIDTH] of the final product, including the last partial product;
  - overflow <= OR of product bits [2*WIDTH-1 : WIDTH+FRAC_WIDTH]; 0 when that range is empty;
  - done <= 1.
- DONE: lasts exactly one cycle with done=1. go is ignored. Next edge: done <= 0, go to IDLE.
- Latency: done is high in the cycle following the WIDTH-th edge after the start edge. WIDTH+2 cycles from start edge to the next possible start edge.
- go held high continuously: a new operation starts on the first IDLE edge after DONE, using the current value of in.
- go pulses while in RUN or DONE are ignored; there is no queueing.
- in may change freely after the start edge; only the captured value is used.
- Truncation: fractional bits below FRAC_WIDTH are discarded (round toward zero). Integer bits above WIDTH are dropped and flagged via overflow.
- idx width is $clog2(WIDTH) bits, with no wrap within an operation.
- out and overflow change only on the completion edge or on reset.

Test Plan:
- WIDTH=8, FRAC_WIDTH=0, in=12, go for 1 cycle:
  - done pulses exactly 1 cycle, 8 cycles after the start edge;
  - out=144, overflow=0.
- WIDTH=8, FRAC_WIDTH=0, in=16 -> out=0, overflow=1.
- WIDTH=8, FRAC_WIDTH=0, in=255 -> out=0x01, overflow=1 (product 0xFE01).
- WIDTH=32, FRAC_WIDTH=16:
  - in=0x00018000 (1.5) -> out=0x00024000 (2.25), overflow=0;
  - in=0x00000001 -> out=0 (truncated fraction), overflow=0.
- Control edge cases:
  - go re-pulsed during RUN -> ignored; a single done, result from the first operand;
  - go held high across two operations with in changed -> two back-to-back results, WIDTH+2 cycles apart.
- Reset asserted mid-RUN (async, between edges):
  - out, done and overflow immediately 0, state IDLE, no done pulse;
  - after release, a fresh go with in=3 (WIDTH=8, FRAC_WIDTH=0) -> out=9.

Source files
------------

// File: rtl/fp_square_seq.sv
// Iterative unsigned fixed-point squarer: out = (in*in) >> FRAC_WIDTH.
// One multiplier bit per cycle; go/done handshake shared with other math units.
module fp_square_seq #(
  parameter int WIDTH      = 32,
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             overflow
);

  localparam int IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int OVF_LSB = INT_WIDTH + 2 * FRAC_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] addend;
  logic [IW-1:0]      idx_q, idx_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      out_q    <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      out_q    <= out_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    out_d    = out_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    addend   = '0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          mcand_d  = in;
          mplier_d = in;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) begin
          addend = {{WIDTH{1'b0}}, mcand_q} << idx_q;
        end
        acc_d    = acc_q + addend;
        mplier_d = mplier_q >> 1;
        // Final iteration publishes the product including this partial.
        if (idx_q == IW'(WIDTH - 1)) begin
          state_d = DONE;
          out_d   = acc_d[FRAC_WIDTH +: WIDTH];
          ovf_d   = |(acc_d >> OVF_LSB);
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out      = out_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule
